dmem_responder: RTL and testbench

- Data-memory responder: the target end of the processor's data-memory interface (memwrite / address / write data / read data).
- Adds a request/acknowledge handshake with programmable wait states, so the multicycle and pipelined cores can be tested against a realistic slow memory instead of a zero-latency array.
- Owns a word-addressed storage array.
- Flags misaligned or out-of-range accesses with an error acknowledge instead of touching storage.

---
 rtl/mem_pkg.sv | 16 +
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_array.sv | 25 ++
 rtl/dmem_responder.sv | 122 ++++++++++++
 tb/tb_dmem_responder.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding,
// wait-state limit and the address alignment mask.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam int MAX_LAT = 15;

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/acknowledge data-memory bus between a core (master) and the
// responder (slave).
interface dmem_responder_if #(
  parameter int AW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          ack;
  logic          err;
  logic [31:0]   rdata;
  logic          busy;

  modport master (
    output req, we, addr, wdata,
    input  ack, err, rdata, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, err, rdata, busy
  );
endinterface

// File: rtl/dmem_array.sv
// Word storage: synchronous write, combinational read. No reset, so the
// contents survive a responder reset.
module dmem_array #(
  parameter int DEPTH = 64,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] idx,
  input  logic [31:0]   wd,
  output logic [31:0]   rd
);

  logic [31:0] mem_q [DEPTH];

  // Write port, committed on the responder's RESP edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wd;
    end
  end

  assign rd = mem_q[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts a request, waits LAT cycles, then performs
// the latched access and pulses ack. Misaligned or out-of-range addresses
// are answered with err instead of touching storage.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int LAT   = 2,
  parameter int AW    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  dmem_responder_if.slave  bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] LAT_C = CW'(LAT);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          busy_q, busy_d;

  logic          addr_err;
  logic          mem_we;
  logic [IW-1:0] idx;
  logic [31:0]   mem_rd;

  // Checks use the latched address only; bus changes after acceptance are ignored.
  assign idx      = addr_q[IW+1:2];
  assign addr_err = ((addr_q[1:0] & ALIGN_MASK) != 2'b00) ||
                    (addr_q[AW-1:IW+2] != '0);
  assign mem_we   = (state_q == RESP) && we_q && !addr_err;

  dmem_array #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_array (
    .clk (clk),
    .we  (mem_we),
    .idx (idx),
    .wd  (wdata_q),
    .rd  (mem_rd)
  );

  // Next-state, latch and response logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        busy_d = bus.req;
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          cnt_d   = LAT_C;
          state_d = (LAT_C == '0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        ack_d = 1'b1;
        err_d = addr_err;
        if (!we_q && !addr_err) begin
          rdata_d = mem_rd;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any in-flight access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LAT = 0, 2, 15) share the
// stimulus; sel_i (equal to the instance's LAT) picks which one sees req
// and whose outputs are observed.
module tb_dmem_responder;

  logic        clk;
  logic        reset_n;
  logic [3:0]  sel_i;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ack_m;
  logic        err_m;
  logic [31:0] rdata_m;
  logic        busy_m;

  int pass_cnt;
  int total_cnt;

  dmem_responder_if #(.AW(32)) if0 ();
  dmem_responder_if #(.AW(32)) if2 ();
  dmem_responder_if #(.AW(32)) if15 ();

  dmem_responder #(.DEPTH(64), .LAT(0),  .AW(32)) u_lat0  (.clk(clk), .reset_n(reset_n), .bus(if0));
  dmem_responder #(.DEPTH(64), .LAT(2),  .AW(32)) u_lat2  (.clk(clk), .reset_n(reset_n), .bus(if2));
  dmem_responder #(.DEPTH(64), .LAT(15), .AW(32)) u_lat15 (.clk(clk), .reset_n(reset_n), .bus(if15));

  assign if0.req    = req_i && (sel_i == 4'd0);
  assign if0.we     = we_i;
  assign if0.addr   = addr_i;
  assign if0.wdata  = wdata_i;
  assign if2.req    = req_i && (sel_i == 4'd2);
  assign if2.we     = we_i;
  assign if2.addr   = addr_i;
  assign if2.wdata  = wdata_i;
  assign if15.req   = req_i && (sel_i == 4'd15);
  assign if15.we    = we_i;
  assign if15.addr  = addr_i;
  assign if15.wdata = wdata_i;

  assign ack_m   = (sel_i == 4'd0) ? if0.ack   : (sel_i == 4'd2) ? if2.ack   : if15.ack;
  assign err_m   = (sel_i == 4'd0) ? if0.err   : (sel_i == 4'd2) ? if2.err   : if15.err;
  assign rdata_m = (sel_i == 4'd0) ? if0.rdata : (sel_i == 4'd2) ? if2.rdata : if15.rdata;
  assign busy_m  = (sel_i == 4'd0) ? if0.busy  : (sel_i == 4'd2) ? if2.busy  : if15.busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  // Waits (bounded) for ack after an acceptance edge; n counts edges,
  // nb counts cycles with busy high, both up to and including the ack cycle.
  task automatic wait_ack(output int n, output int nb);
    n  = 0;
    nb = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (busy_m) nb++;
      if (ack_m) break;
    end
  endtask

  task automatic do_txn(input string nm, input logic [3:0] sel, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic err, input logic [31:0] rdata);
    int n, nb;
    @(negedge clk);
    sel_i   = sel;
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = addr;
    wdata_i = wdata;
    @(posedge clk);
    wait_ack(n, nb);
    req_i = 1'b0;
    chk({nm, "_latency"}, 32'(n), 32'(sel) + 32'd1);
    chk({nm, "_busy_cycles"}, 32'(nb), 32'(sel) + 32'd1);
    chk({nm, "_err"}, {31'd0, err_m}, {31'd0, err});
    chk({nm, "_rdata"}, rdata_m, rdata);
    @(negedge clk);
    chk({nm, "_ack_drop"}, {31'd0, ack_m}, 32'd0);
    chk({nm, "_busy_drop"}, {31'd0, busy_m}, 32'd0);
  endtask

  initial begin
    int n, nb, seen;
    logic got;

    pass_cnt  = 0;
    total_cnt = 0;
    reset_n   = 1'b0;
    sel_i     = 4'd2;
    req_i     = 1'b0;
    we_i      = 1'b0;
    addr_i    = '0;
    wdata_i   = '0;

    vecs[0]  = '{4'd2,  1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{4'd2,  1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{4'd2,  1'b1, 32'h04,  32'hCAFEF00D, 1'b0, 32'hDEADBEEF};
    vecs[3]  = '{4'd2,  1'b1, 32'h06,  32'h12345678, 1'b1, 32'hDEADBEEF};
    vecs[4]  = '{4'd2,  1'b0, 32'h04,  32'h0,        1'b0, 32'hCAFEF00D};
    vecs[5]  = '{4'd2,  1'b0, 32'h100, 32'h0,        1'b1, 32'hCAFEF00D};
    vecs[6]  = '{4'd2,  1'b1, 32'hFC,  32'hA5A5A5A5, 1'b0, 32'hCAFEF00D};
    vecs[7]  = '{4'd2,  1'b0, 32'hFC,  32'h0,        1'b0, 32'hA5A5A5A5};
    vecs[8]  = '{4'd2,  1'b0, 32'h03,  32'h0,        1'b1, 32'hA5A5A5A5};
    vecs[9]  = '{4'd2,  1'b1, 32'h20,  32'h01234567, 1'b0, 32'hA5A5A5A5};
    vecs[10] = '{4'd0,  1'b1, 32'h00,  32'h11111111, 1'b0, 32'h0};
    vecs[11] = '{4'd0,  1'b1, 32'h04,  32'h22222222, 1'b0, 32'h0};

    #12;
    chk("rst_ack",   {29'd0, if0.ack, if2.ack, if15.ack}, 32'd0);
    chk("rst_err",   {29'd0, if0.err, if2.err, if15.err}, 32'd0);
    chk("rst_busy",  {29'd0, if0.busy, if2.busy, if15.busy}, 32'd0);
    chk("rst_rdata", if0.rdata | if2.rdata | if15.rdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].sel, vecs[i].we, vecs[i].addr,
             vecs[i].wdata, vecs[i].err, vecs[i].rdata);
    end

    // LAT=0 back-to-back reads with req held high.
    @(negedge clk);
    sel_i  = 4'd0;
    req_i  = 1'b1;
    we_i   = 1'b0;
    addr_i = 32'h0;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_first_resp_ack", {31'd0, ack_m}, 32'd0);
    chk("b2b_first_resp_busy", {31'd0, busy_m}, 32'd1);
    addr_i = 32'h4;
    @(negedge clk);
    chk("b2b_ack1", {31'd0, ack_m}, 32'd1);
    chk("b2b_rdata1", rdata_m, 32'h11111111);
    @(negedge clk);
    chk("b2b_gap_ack", {31'd0, ack_m}, 32'd0);
    chk("b2b_gap_busy", {31'd0, busy_m}, 32'd1);
    @(negedge clk);
    chk("b2b_ack2", {31'd0, ack_m}, 32'd1);
    chk("b2b_rdata2", rdata_m, 32'h22222222);
    chk("b2b_err2", {31'd0, err_m}, 32'd0);
    req_i = 1'b0;
    @(negedge clk);
    chk("b2b_end_ack", {31'd0, ack_m}, 32'd0);
    chk("b2b_end_busy", {31'd0, busy_m}, 32'd0);

    // Reset during WAIT of a LAT=2 write to 0x20.
    @(negedge clk);
    sel_i   = 4'd2;
    req_i   = 1'b1;
    we_i    = 1'b1;
    addr_i  = 32'h20;
    wdata_i = 32'hFFFF0000;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy_before", {31'd0, busy_m}, 32'd1);
    reset_n = 1'b0;
    req_i   = 1'b0;
    #1;
    chk("abort_ack", {31'd0, ack_m}, 32'd0);
    chk("abort_busy", {31'd0, busy_m}, 32'd0);
    chk("abort_rdata", rdata_m, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack_m) seen++;
    end
    chk("abort_no_ack", 32'(seen), 32'd0);
    do_txn("abort_readback", 4'd2, 1'b0, 32'h20, 32'h0, 1'b0, 32'h01234567);

    // LAT=15: preload, then read with req/we/addr wiggling during WAIT.
    do_txn("lat15_wr", 4'd15, 1'b1, 32'h8, 32'h0BADF00D, 1'b0, 32'h0);
    @(negedge clk);
    sel_i  = 4'd15;
    req_i  = 1'b1;
    we_i   = 1'b0;
    addr_i = 32'h8;
    @(posedge clk);
    n   = 0;
    nb  = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (busy_m) nb++;
      if (ack_m) got = 1'b1;
      else begin
        req_i   = ~req_i;
        we_i    = 1'b1;
        wdata_i = 32'hFFFFFFFF;
        addr_i  = 32'hC;
      end
    end
    req_i = 1'b0;
    we_i  = 1'b0;
    chk("lat15_latency", 32'(n), 32'd16);
    chk("lat15_busy_cycles", 32'(nb), 32'd16);
    chk("lat15_err", {31'd0, err_m}, 32'd0);
    chk("lat15_rdata", rdata_m, 32'h0BADF00D);
    @(negedge clk);
    chk("lat15_ack_drop", {31'd0, ack_m}, 32'd0);
    chk("lat15_busy_drop", {31'd0, busy_m}, 32'd0);
    do_txn("lat15_reread", 4'd15, 1'b0, 32'h8, 32'h0, 1'b0, 32'h0BADF00D);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
